arb_requester: RTL and testbench
================================

# arb_requester

Client-side agent for the three-way fixed-priority request/grant arbiter. It accepts a job from local logic, raises `req`, and transfers `job_len` beats in the cycles where `grant` is high. It resumes after preemption, aborts on a grant timeout, and handles the arbiter's one-cycle registered grant latency, including the stale grant seen after `req` drops. One instance sits on each arbiter request port.

## Interface
Parameters:
- `LEN_W`, default 4: width of `job_len` and `beat_idx`.
- `TIMEOUT`, default 16: consecutive un-granted ACTIVE cycles before the job is aborted. A value of 0 disables the timeout.
- `TO_W`, default 5: width of the wait counter. Must satisfy TIMEOUT ≤ 2^TO_W − 1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `job_valid`  in  1  a job is offered.
- `job_len`  in  LEN_W  number of beats in the offered job; 0 is legal.
- `job_ready`  out  1  the block can accept a job; equals (state == IDLE).
- `req`  out  1  request to the arbiter, registered.
- `grant`  in  1  grant from the arbiter, registered on the arbiter side.
- `beat`  out  1  a beat transfers this cycle, combinational.
- `beat_idx`  out  LEN_W  index of the current beat: 0..len−1.
- `done`  out  1  one-cycle pulse when a job completes.
- `timeout`  out  1  one-cycle pulse when a job is aborted.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States are IDLE, ACTIVE and RELEASE.
- IDLE:
  - A job is accepted when `job_valid` and `job_ready` are both high.
  - The block latches `remaining` = `job_len`, then clears `beat_idx` and `wait_cnt`.
  - If `job_len` ≠ 0, the next state is ACTIVE.
  - If `job_len` == 0, the block stays in IDLE and pulses `done` the next cycle. `req` is never raised in this case.
- ACTIVE:
  - `req` = 1.
  - `beat` = `grant`.
  - On a beat:
    - `remaining` decrements.
    - `beat_idx` increments.
    - `wait_cnt` clears.
  - If the beat has `remaining` == 1, the next state is RELEASE and `done` is registered to 1.
  - When `grant` is low:
    - `wait_cnt` increments.
    - If TIMEOUT ≠ 0 and `wait_cnt` == TIMEOUT−1, the next state is RELEASE and `timeout` is registered to 1. The unfinished beats are discarded.
  - Preemption (grant drops mid-burst) only pauses beats. `beat_idx` resumes where it stopped and nothing is retransferred.
- RELEASE:
  - Lasts exactly one cycle.
  - `req` = 0 and `beat` = 0.
  - `grant` is ignored. It may still be 1 here because it reflects `req` from the previous cycle.
  - `job_ready` = 0.
  - The next state is IDLE.
- Width and priority rules:
  - `remaining` and `beat_idx` are LEN_W bits and never wrap, because len ≤ 2^LEN_W − 1.
  - A beat and a timeout cannot coincide, since the timeout requires `grant` = 0.
  - `done` and `timeout` are mutually exclusive.
- `grant` arriving while in IDLE is a protocol violation. It is ignored, with `beat` = 0.

## Timing
- Reset values: state IDLE, `req` 0, `beat` 0, `beat_idx` 0, `done` 0, `timeout` 0, `busy` 0, `job_ready` 1 (from the first cycle after reset), `remaining` 0, `wait_cnt` 0.
- Reset mid-burst: at the next edge with `rst_n` low, the block returns to IDLE and `req` drops. There is no `done` or `timeout` pulse.
- Cycle-level sequence:
  - Job accepted in cycle t → `req` = 1 in cycle t+1.
  - The earliest grant or beat is in cycle t+2.
  - Final beat in cycle f → RELEASE in f+1 with `done` = 1 and `req` = 0 → `job_ready` = 1 in f+2.
  - Minimum job-to-job spacing: len + 3 cycles at full grant.
- `done` and `timeout` are high for exactly one cycle. They coincide with RELEASE, except for a len = 0 job, where `done` is high in the cycle after acceptance and the block stays in IDLE.
- `job_valid` held high is accepted again as soon as `job_ready` returns, so back-to-back jobs need no bubble beyond RELEASE.

## Test plan
- Job len = 3 accepted in cycle 0, with an ideal arbiter (grant = req delayed 1 cycle) → `req` high cycles 1–4; beats in cycles 2, 3, 4 with `beat_idx` 0, 1, 2; `done` in cycle 5 with a stale grant = 1 in cycle 5 and `beat` = 0; `job_ready` high in cycle 6.
- len = 3, grant high in cycles 2, 5, 6 only (preemption in cycles 3–4) → beats with idx 0, 1, 2 in cycles 2, 5, 6; `done` in cycle 7; `wait_cnt` 2 at cycle 5, then cleared.
- TIMEOUT = 4, grant never asserted, len = 5 → `req` high cycles 1–4; `timeout` pulse and `req` = 0 in cycle 5; no `done`; `job_ready` high in cycle 6.
- len = 0 job in cycle 0 → `done` pulse in cycle 1; `req` stays 0; `job_ready` stays 1.
- len = 4, `rst_n` low in cycle 3 after 1 beat → IDLE with `req` = 0 in cycle 4; no `done` or `timeout`; a new len = 2 job completes normally afterwards.
- `job_valid` held high with len = 2, twice, ideal arbiter → accepts in cycles 0 and 5; `done` in cycles 4 and 9; exactly 4 beats in total.

Source files
------------

// File: rtl/arb_requester.sv
// Client-side request agent for the fixed-priority arbiter: takes a job, holds req,
// moves one beat per granted cycle, and gives up after TIMEOUT un-granted cycles.
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid_i,
    input  logic [LEN_W-1:0] job_len_i,
    output logic             job_ready_o,
    output logic             req_o,
    input  logic             grant_i,
    output logic             beat_o,
    output logic [LEN_W-1:0] beat_idx_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [LEN_W-1:0]  beat_idx_q;
    logic [TO_W-1:0]   wait_cnt_q;
    logic              req_q;
    logic              done_q;
    logic              timeout_q;
    logic              to_hit;

    // Grant in IDLE or RELEASE is ignored: in RELEASE it is the stale echo of last cycle's req.
    assign beat_o      = (state_q == ACTIVE) && grant_i;
    assign job_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign req_o       = req_q;
    assign beat_idx_o  = beat_idx_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign to_hit      = (TIMEOUT != 0) && (wait_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            beat_idx_q  <= '0;
            wait_cnt_q  <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (job_valid_i) begin
                        remaining_q <= job_len_i;
                        beat_idx_q  <= '0;
                        wait_cnt_q  <= '0;
                        if (job_len_i != '0) begin
                            state_q <= ACTIVE;
                            req_q   <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (grant_i) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        beat_idx_q  <= beat_idx_q + LEN_W'(1);
                        wait_cnt_q  <= '0;
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= RELEASE;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        // Saturate so a disabled timeout never wraps the counter.
                        if (wait_cnt_q != '1)
                            wait_cnt_q <= wait_cnt_q + TO_W'(1);
                        if (to_hit) begin
                            state_q   <= RELEASE;
                            req_q     <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: constant vector tables for the documented cycle sequences,
// directed multi-cycle corners, and random traffic against a job-level reference model.
module tb_arb_requester;
    localparam int LW  = 4;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic [LW-1:0] job_len;
    logic          job_ready, req, grant, beat, done, tmo_o, busy;
    logic [LW-1:0] beat_idx;

    arb_requester #(.LEN_W(LW), .TIMEOUT(TMO), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid_i(job_valid), .job_len_i(job_len), .job_ready_o(job_ready),
        .req_o(req), .grant_i(grant), .beat_o(beat), .beat_idx_o(beat_idx),
        .done_o(done), .timeout_o(tmo_o), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit jv; int jl; bit gr; bit rn;
        bit e_req; bit e_beat; int e_idx; bit e_done; bit e_to; bit e_rdy;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    // Reference model: job view (phase 0 idle, 1 requesting, 2 one-cycle release).
    int m_ph, m_left, m_idx, m_wait;
    bit m_done, m_to;
    int o_beat, o_done, beat_cnt, done_cnt;

    function automatic vec_t mk(bit jv, int jl, bit gr, bit e_req, bit e_beat, int e_idx,
                                bit e_done, bit e_to, bit e_rdy);
        vec_t v;
        v.jv = jv; v.jl = jl; v.gr = gr; v.rn = 1'b1;
        v.e_req = e_req; v.e_beat = e_beat; v.e_idx = e_idx;
        v.e_done = e_done; v.e_to = e_to; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_tick(bit jv, int jl, bit gr, bit rn);
        bit nd = 0, nt = 0;
        if (!rn) begin
            m_ph = 0; m_left = 0; m_idx = 0; m_wait = 0; m_done = 0; m_to = 0;
            return;
        end
        case (m_ph)
            0: if (jv) begin
                   m_left = jl; m_idx = 0; m_wait = 0;
                   if (jl == 0) nd = 1; else m_ph = 1;
               end
            1: if (gr) begin
                   m_left--; m_idx++; m_wait = 0;
                   if (m_left == 0) begin m_ph = 2; nd = 1; end
               end else begin
                   m_wait++;
                   if (TMO != 0 && m_wait >= TMO) begin m_ph = 2; nt = 1; end
               end
            default: m_ph = 0;
        endcase
        m_done = nd; m_to = nt;
    endtask

    // One clock: drive, compare on the falling edge, advance the model on the rising edge.
    task automatic step(vec_t v, bit use_tbl);
        bit mbeat;
        job_valid = v.jv; job_len = LW'(v.jl); grant = v.gr; rst_n = v.rn;
        @(negedge clk);
        mbeat = (m_ph == 1) && v.gr;
        o_beat = int'(beat); o_done = int'(done);
        beat_cnt += o_beat; done_cnt += o_done;
        if (use_tbl) begin
            chk("t_req", req, v.e_req);
            chk("t_beat", beat, v.e_beat);
            if (v.e_beat) chk("t_idx", beat_idx, v.e_idx);
            chk("t_done", done, v.e_done);
            chk("t_timeout", tmo_o, v.e_to);
            chk("t_ready", job_ready, v.e_rdy);
        end else if (req !== (m_ph == 1) || beat !== mbeat || done !== m_done ||
                     tmo_o !== m_to || job_ready !== (m_ph == 0) || busy !== (m_ph != 0) ||
                     (mbeat && beat_idx !== LW'(m_idx))) begin
            total++; bad++;
            $display("FAIL model @%0t: req=%b beat=%b idx=%0d done=%b to=%b rdy=%b busy=%b want req=%0d beat=%0d idx=%0d done=%0d to=%0d ph=%0d",
                     $time, req, beat, beat_idx, done, tmo_o, job_ready, busy,
                     m_ph == 1, mbeat, m_idx, m_done, m_to, m_ph);
        end else total++;
        @(posedge clk);
        model_tick(v.jv, v.jl, v.gr, v.rn);
        #1;
    endtask

    function automatic vec_t in(bit jv, int jl, bit gr, bit rn);
        vec_t v = mk(jv, jl, gr, 0, 0, 0, 0, 0, 0);
        v.rn = rn;
        return v;
    endfunction

    initial begin
        int pr, done_at;
        bit g;
        rst_n = 1'b0; job_valid = 1'b0; job_len = '0; grant = 1'b0;
        repeat (2) @(posedge clk);
        model_tick(0, 0, 0, 0);
        #1;

        // Reset state
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", job_ready, 1); chk("rst_req", req, 0); chk("rst_beat", beat, 0);
        chk("rst_done", done, 0); chk("rst_to", tmo_o, 0); chk("rst_busy", busy, 0);
        chk("rst_idx", beat_idx, 0);
        @(posedge clk); #1;

        // len=3, ideal arbiter: beats 2..4, done with stale grant in 5
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        // TIMEOUT=4, no grant, len=5
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        // len=0: done next cycle, never requests
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Preemption: grant only in cycles 2, 5, 6
        done_at = -1; beat_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            g = (c == 2 || c == 5 || c == 6);
            step(in(c == 0, 3, g, 1), 1'b0);
            if (o_done != 0) done_at = c;
            if (c == 3 || c == 4) chk("pre_nobeat", o_beat, 0);
        end
        chk("pre_done_cycle", done_at, 7);
        chk("pre_beats", beat_cnt, 3);

        // Reset mid-burst after one beat, then a clean len=2 job
        done_cnt = 0;
        step(in(1, 4, 0, 1), 1'b0);
        step(in(0, 0, 0, 1), 1'b0);
        step(in(0, 0, 1, 1), 1'b0);
        step(in(0, 0, 1, 0), 1'b0);
        step(in(0, 0, 0, 1), 1'b0);
        chk("rst_mid_done", done_cnt, 0);
        chk("rst_mid_ready", job_ready, 1);
        chk("rst_mid_to", tmo_o, 0);
        pr = 0;
        for (int c = 0; c < 6; c++) begin
            g = pr[0]; pr = (m_ph == 1);
            step(in(c == 0, 2, g, 1), 1'b0);
        end
        chk("rst_mid_next_done", done_cnt, 1);

        // job_valid held: accepts in 0 and 5, done in 4 and 9
        pr = 0; beat_cnt = 0; done_cnt = 0; done_at = 0;
        for (int c = 0; c < 11; c++) begin
            g = pr[0]; pr = (m_ph == 1);
            if (c == 0 || c == 5) chk("b2b_ready", job_ready, 1);
            step(in(c <= 5, 2, g, 1), 1'b0);
            if (o_done != 0) done_at += c;
        end
        chk("b2b_beats", beat_cnt, 4);
        chk("b2b_dones", done_cnt, 2);
        chk("b2b_done_cycles", done_at, 13);

        // Random traffic, including stray grants in IDLE and occasional reset
        for (int c = 0; c < 4000; c++) begin
            step(in($urandom_range(0, 3) == 0, $urandom_range(0, 15),
                    $urandom_range(0, 99) < 60, $urandom_range(0, 299) != 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
